dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
//  MEM-stage load/store initiator for the data RAM: accepts one load/store per handshake from the pipeline,
//  drives the RAM's word-wide write/read port, and returns aligned, extended load data. Sub-word stores are
//  done by read-modify-write because the RAM writes whole words only. Sits between the EX/MEM register and the RAM.
// PARAMETERS
//  PARK_ADDR  32'hFFFF_FFFC  word address driven on mem_read_address outside READ; never a data address
// PORTS
//  clk                in   1   single clock; all state updates on posedge
//  rst_n              in   1   asynchronous, active-low reset
//  req_valid          in   1   pipeline request present
//  req_ready          out  1   LSU can accept (high only in IDLE)
//  req_write          in   1   1 = store, 0 = load
//  req_size           in   2   SZ_BYTE/SZ_HALF/SZ_WORD (dmem_pkg)
//  req_signed         in   1   loads: 1 = sign-extend, 0 = zero-extend
//  req_addr           in   `ADDRESS_SIZE  byte address
//  req_wdata          in   `DATA_SIZE     store data, right-justified
//  resp_valid         out  1   one-cycle completion pulse (loads and stores)
//  resp_rdata         out  `DATA_SIZE     extended load data; 0 for stores/errors
//  resp_misalign      out  1   qualifies resp_valid: request misaligned, no RAM access made
//  mem_write_enable   out  1   to RAM write_enable
//  mem_write_address  out  `ADDRESS_SIZE  to RAM write_address (always word-aligned)
//  mem_write_data     out  `DATA_SIZE     to RAM write_data
//  mem_read_address   out  `ADDRESS_SIZE  to RAM read_address
//  mem_read_data      in   `DATA_SIZE     from RAM read_data (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; req_ready=1 after release; resp_valid=0, resp_rdata=0, resp_misalign=0;
//   mem_write_enable=0 (never X/Z: RAM clears itself on X), mem_write_address=0, mem_write_data=0,
//   mem_read_address=PARK_ADDR. Reset mid-op aborts it: no write, no response.
//  Accept: req_valid & req_ready at posedge; request fields registered; req_ready drops next cycle.
//  Byte order big-endian: offset addr[1:0]=k occupies bits [31-8k -: 8]; half at k=0 -> [31:16], k=2 -> [15:0].
//  Misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0): IDLE->RESP, resp_misalign=1, no RAM activity.
//  States: IDLE, READ, WRITE, RESP.
//   IDLE -> READ   load, or sub-word store (aligned)
//   IDLE -> WRITE  word store
//   READ -> RESP   load: capture mem_read_data at end of READ, extract + extend into resp_rdata
//   READ -> WRITE  sub-word store: merge req_wdata lane(s) into captured word
//   WRITE -> RESP ; RESP -> IDLE (resp_valid=1 during RESP only)
//  READ: mem_write_enable=0, mem_read_address={addr[31:2],2'b00}; PARK_ADDR elsewhere so every READ
//   produces an address change at the RAM (RAM read is event-driven on address).
//  WRITE: mem_write_enable=1 for exactly one cycle; mem_write_address={addr[31:2],2'b00}; RAM commits at
//   the posedge ending WRITE.
//  Latency (accept edge = cycle 0): load resp_valid in cycle 2; word store 2; sub-word store 3; misaligned 1.
//  Load of never-written word: RAM returns X; LSU passes it through (no masking).
//  Request to word PARK_ADDR is a software error; behaviour undefined.
// STRUCTURE
//  dmem_pkg: size_e {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10}, lsu_state_e, alignment-check function.
//  Widths from defines.vh (`ADDRESS_SIZE, `DATA_SIZE).
//  Sub-module dmem_lane_align (combinational): extract+extend for loads, lane merge for stores.
// TESTING
//  sw 32'hDEADBEEF @0x100, then lw @0x100 -> one we pulse, addr 0x100; load resp_rdata=32'hDEADBEEF, cycle 2.
//  After above, sb 8'h5A @0x102 -> READ then WRITE data 32'hDEAD5AEF; lb signed @0x102 -> 32'h0000005A.
//  lh signed @0x100 -> 32'hFFFFDEAD; lh unsigned @0x100 -> 32'h0000DEAD; lbu @0x103 -> 32'h000000EF.
//  lw @0x102 -> resp_misalign=1 in cycle 1, resp_rdata=0, mem_write_enable stays 0, no READ.
//  rst_n low during WRITE of sb -> mem_write_enable=0 immediately, word @0x100 unchanged, no resp_valid.
//  Back-to-back: req_valid held high -> req_ready low while busy; no request lost or duplicated.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and alignment check for the data-memory LSU
package dmem_pkg;

  localparam int ADDRESS_SIZE = 32;
  localparam int DATA_SIZE    = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } lsu_state_e;

  // Any size other than byte/half is treated as a word access.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return offset[0];
      default: return offset != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian lane extract/extend for loads and lane merge for stores
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e                 size_i,
  input  logic                  signed_i,
  input  logic [1:0]            offset_i,
  input  logic [DATA_SIZE-1:0]  word_i,
  input  logic [DATA_SIZE-1:0]  wdata_i,
  output logic [DATA_SIZE-1:0]  load_o,
  output logic [DATA_SIZE-1:0]  merge_o
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Offset k sits at bit 31-8k, so the right-shift amount is (3-k)*8 for bytes, (2-k)*8 for halves.
  assign byte_sh = {~offset_i, 3'b000};
  assign half_sh = {~offset_i[1], 4'b0000};
  assign lane_b  = 8'(word_i >> byte_sh);
  assign lane_h  = 16'(word_i >> half_sh);

  always_comb begin
    load_o  = word_i;
    merge_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o  = {{(DATA_SIZE-8){signed_i & lane_b[7]}}, lane_b};
        merge_o = (word_i & ~(DATA_SIZE'(8'hFF) << byte_sh))
                | (DATA_SIZE'(wdata_i[7:0]) << byte_sh);
      end
      SZ_HALF: begin
        load_o  = {{(DATA_SIZE-16){signed_i & lane_h[15]}}, lane_h};
        merge_o = (word_i & ~(DATA_SIZE'(16'hFFFF) << half_sh))
                | (DATA_SIZE'(wdata_i[15:0]) << half_sh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - MEM-stage load/store initiator with read-modify-write for sub-word stores
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter logic [ADDRESS_SIZE-1:0] PARK_ADDR = 32'hFFFF_FFFC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  output logic                    resp_valid,
  output logic [DATA_SIZE-1:0]    resp_rdata,
  output logic                    resp_misalign,
  output logic                    mem_write_enable,
  output logic [ADDRESS_SIZE-1:0] mem_write_address,
  output logic [DATA_SIZE-1:0]    mem_write_data,
  output logic [ADDRESS_SIZE-1:0] mem_read_address,
  input  logic [DATA_SIZE-1:0]    mem_read_data
);

  lsu_state_e              state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  size_e                   size_q, size_d;
  logic                    signed_q, signed_d;
  logic                    write_q, write_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic                    misalign_q, misalign_d;
  // Holds the word to write while in WRITE and the extended load result while in RESP.
  logic [DATA_SIZE-1:0]    data_q, data_d;

  logic [DATA_SIZE-1:0]    load_data;
  logic [DATA_SIZE-1:0]    merge_data;
  logic [ADDRESS_SIZE-1:0] word_addr;
  size_e                   req_size_e;

  assign req_size_e = size_e'(req_size);
  assign word_addr  = {addr_q[ADDRESS_SIZE-1:2], 2'b00};

  dmem_lane_align u_lane_align (
    .size_i   (size_q),
    .signed_i (signed_q),
    .offset_i (addr_q[1:0]),
    .word_i   (mem_read_data),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      size_q     <= SZ_BYTE;
      signed_q   <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      misalign_q <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      misalign_q <= misalign_d;
      data_q     <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    misalign_d = misalign_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size_e;
          signed_d   = req_signed;
          write_d    = req_write;
          wdata_d    = req_wdata;
          misalign_d = is_misaligned(req_size_e, req_addr[1:0]);
          data_d     = '0;
          if (is_misaligned(req_size_e, req_addr[1:0])) begin
            state_d = ST_RESP;
          end else if (req_write && req_size_e != SZ_BYTE && req_size_e != SZ_HALF) begin
            data_d  = req_wdata;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        data_d  = write_q ? merge_data : load_data;
        state_d = write_q ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        data_d  = '0;
        state_d = ST_RESP;
      end
      default: begin
        misalign_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // RAM port is parked outside READ so every READ presents a fresh address.
  assign req_ready         = (state_q == ST_IDLE);
  assign resp_valid        = (state_q == ST_RESP);
  assign resp_rdata        = (state_q == ST_RESP) ? data_q : '0;
  assign resp_misalign     = (state_q == ST_RESP) && misalign_q;
  assign mem_write_enable  = (state_q == ST_WRITE);
  assign mem_write_address = (state_q == ST_WRITE) ? word_addr : '0;
  assign mem_write_data    = (state_q == ST_WRITE) ? data_q : '0;
  assign mem_read_address  = (state_q == ST_READ) ? word_addr : PARK_ADDR;

endmodule
